// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: transmitter/receiver FSM states and line levels.
package serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } serial_state_e;

    localparam logic LineIdle = 1'b1;
    localparam logic StartBit = 1'b0;
    localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags the last cycle of each bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_FFD,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign tick = enable && !clear && (cnt_q == CntMax);

    always_ff @(posedge clock or posedge reset_FFD) begin
        if (reset_FFD) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_BITS payload LSB first, stop bit; all outputs registered.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset_FFD,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    serial_state_e        state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 timer_en;
    logic                 tick;

    assign timer_en = (state_q != StIdle);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock    (clock),
        .reset_FFD(reset_FFD),
        .clear    (accept),
        .enable   (timer_en),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    accept  = 1'b1;
                    shift_d = tx_data;
                    idx_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) state_d = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registered line lines up with it.
        unique case (state_d)
            StStart: serial_d = StartBit;
            StData:  serial_d = shift_d[0];
            StStop:  serial_d = StopBit;
            default: serial_d = LineIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset_FFD) begin
        if (reset_FFD) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= LineIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: reset, single and back-to-back frames, busy rejection, mid-frame reset, small-parameter frame.
module tb_serial_tx;

    localparam int Clks  = 4;
    localparam int Bits  = 8;
    localparam int SClks = 2;
    localparam int SBits = 5;
    localparam int Frame = (Bits + 2) * Clks;
    localparam int SFrame = (SBits + 2) * SClks;

    logic       clock = 1'b0;
    logic       reset_FFD = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_serial, tx_busy, tx_done;
    logic       s_start = 1'b0;
    logic [4:0] s_data = 5'h00;
    logic       s_serial, s_busy, s_done;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    serial_tx #(
        .CLKS_PER_BIT(Clks),
        .DATA_BITS   (Bits)
    ) dut (
        .clock    (clock),
        .reset_FFD(reset_FFD),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    serial_tx #(
        .CLKS_PER_BIT(SClks),
        .DATA_BITS   (SBits)
    ) dut_small (
        .clock    (clock),
        .reset_FFD(reset_FFD),
        .tx_start (s_start),
        .tx_data  (s_data),
        .tx_serial(s_serial),
        .tx_busy  (s_busy),
        .tx_done  (s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level in cycle n (1-based) after acceptance.
    function automatic logic exp_level(input logic [7:0] data, input int n, input int c, input int d);
        int b;
        b = (n - 1) / c;
        if (b == 0) return 1'b0;
        if (b <= d) return data[b-1];
        return 1'b1;
    endfunction

    // Called before a rising edge; that edge accepts the frame. Returns in the tx_done cycle.
    task automatic run_frame(input logic [7:0] data, input bit poke);
        tx_data  = data;
        tx_start = 1'b1;
        @(posedge clock);
        #1;
        tx_start = 1'b0;
        tx_data  = ~data;
        for (int n = 1; n <= Frame; n++) begin
            @(negedge clock);
            check($sformatf("line %02h c%0d", data, n), tx_serial, exp_level(data, n, Clks, Bits));
            check($sformatf("busy c%0d", n), tx_busy, 1);
            check($sformatf("done c%0d", n), tx_done, 0);
            if (poke && n == 10) begin
                tx_start = 1'b1;
                tx_data  = 8'h3C;
            end
            if (poke && n == 11) begin
                tx_start = 1'b0;
                tx_data  = ~data;
            end
        end
        @(negedge clock);
        check("done pulse", tx_done, 1);
        check("busy at done", tx_busy, 0);
        check("line at done", tx_serial, 1);
    endtask

    task automatic check_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            check($sformatf("%s line", tag), tx_serial, 1);
            check($sformatf("%s busy", tag), tx_busy, 0);
            check($sformatf("%s done", tag), tx_done, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit saw_done;

        // Asynchronous reset between edges, checked before any clock edge.
        #2 reset_FFD = 1'b1;
        #1;
        check("rst line", tx_serial, 1);
        check("rst busy", tx_busy, 0);
        check("rst done", tx_done, 0);
        check("rst s_line", s_serial, 1);
        check("rst s_busy", s_busy, 0);
        @(negedge clock);
        reset_FFD = 1'b0;
        check_idle(3, "post-rst");

        run_frame(8'hA5, 1'b0);
        check_idle(3, "after A5");

        // Second request in the tx_done cycle: no idle gap between frames.
        run_frame(8'h00, 1'b0);
        run_frame(8'hFF, 1'b0);
        check_idle(3, "after b2b");

        // Request mid-frame is ignored and not queued.
        run_frame(8'hA5, 1'b1);
        check_idle(12, "reject");

        // Reset at cycle 20 of a frame whose line is low there.
        @(negedge clock);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(posedge clock);
        #1 tx_start = 1'b0;
        repeat (19) @(posedge clock);
        #2;
        check("pre-rst line low", tx_serial, 0);
        reset_FFD = 1'b1;
        #1;
        check("midrst line", tx_serial, 1);
        check("midrst busy", tx_busy, 0);
        check("midrst done", tx_done, 0);
        @(negedge clock);
        reset_FFD = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tx_done === 1'b1 || tx_serial !== 1'b1) saw_done = 1'b1;
        end
        check("midrst no done/idle", saw_done, 0);
        run_frame(8'h81, 1'b0);

        // Small-parameter instance: 5 data bits, 2 clocks per bit.
        @(negedge clock);
        s_data  = 5'h15;
        s_start = 1'b1;
        @(posedge clock);
        #1;
        s_start = 1'b0;
        s_data  = 5'h0A;
        for (int n = 1; n <= SFrame; n++) begin
            @(negedge clock);
            check($sformatf("s line c%0d", n), s_serial, exp_level(8'h15, n, SClks, SBits));
            check($sformatf("s busy c%0d", n), s_busy, 1);
            check($sformatf("s done c%0d", n), s_done, 0);
        end
        @(negedge clock);
        check("s done pulse", s_done, 1);
        check("s busy at done", s_busy, 0);
        check("s line at done", s_serial, 1);
        @(negedge clock);
        check("s done one cycle", s_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
